// File: rtl/bcd_display_mux.sv
// Two-digit multiplexed 7-segment driver for a packed BCD value, with a blanking gap between digits.
// Optional build macro LEADING_ZERO_BLANK_EN: blank the tens digit when it is 0.
module bcd_display_mux #(
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] bcd_in,
    output logic [6:0] seg,
    output logic [1:0] dig_en,
    output logic       err
);

    localparam logic [15:0] SHOW_LAST = 16'(REFRESH_DIV - 1);
    localparam logic [15:0] GAP_LAST  = 16'(BLANK_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHOW0 = 3'd1,
        GAP0  = 3'd2,
        SHOW1 = 3'd3,
        GAP1  = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [3:0]  units_q, units_nxt;
    logic [3:0]  tens_q, tens_nxt;
    logic [6:0]  seg_q, seg_nxt;
    logic [1:0]  dig_en_q, dig_en_nxt;
    logic        err_q, err_nxt;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h40;
        endcase
    endfunction

    // Next state, phase counter and digit captures. Captures happen only on
    // the transition into a SHOW state, so mid-phase input changes are ignored.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 16'd1;
        units_nxt = units_q;
        tens_nxt  = tens_q;
        if (!ena) begin
            state_nxt = IDLE;
            cnt_nxt   = 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = SHOW0;
                    cnt_nxt   = 16'd0;
                    units_nxt = bcd_in[3:0];
                end
                SHOW0: begin
                    if (cnt == SHOW_LAST) begin
                        state_nxt = GAP0;
                        cnt_nxt   = 16'd0;
                    end
                end
                GAP0: begin
                    if (cnt == GAP_LAST) begin
                        state_nxt = SHOW1;
                        cnt_nxt   = 16'd0;
                        tens_nxt  = bcd_in[7:4];
                    end
                end
                SHOW1: begin
                    if (cnt == SHOW_LAST) begin
                        state_nxt = GAP1;
                        cnt_nxt   = 16'd0;
                    end
                end
                GAP1: begin
                    if (cnt == GAP_LAST) begin
                        state_nxt = SHOW0;
                        cnt_nxt   = 16'd0;
                        units_nxt = bcd_in[3:0];
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = 16'd0;
                end
            endcase
        end
    end

    // Outputs are derived from the next state so the registered pins line up
    // with the state register; dig_en and seg always switch on the same edge.
    always_comb begin
        seg_nxt    = 7'h00;
        dig_en_nxt = 2'b00;
        case (state_nxt)
            SHOW0: begin
                dig_en_nxt = 2'b01;
                seg_nxt    = seg_decode(units_nxt);
            end
            SHOW1: begin
`ifdef LEADING_ZERO_BLANK_EN
                if (tens_nxt != 4'd0) begin
                    dig_en_nxt = 2'b10;
                    seg_nxt    = seg_decode(tens_nxt);
                end
`else
                dig_en_nxt = 2'b10;
                seg_nxt    = seg_decode(tens_nxt);
`endif
            end
            default: begin
                seg_nxt    = 7'h00;
                dig_en_nxt = 2'b00;
            end
        endcase
    end

    // Checking the held captures gives the one-cycle-after-capture latency.
    always_comb begin
        err_nxt = err_q | (units_q > 4'd9) | (tens_q > 4'd9);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 16'd0;
            units_q  <= 4'd0;
            tens_q   <= 4'd0;
            seg_q    <= 7'h00;
            dig_en_q <= 2'b00;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            units_q  <= units_nxt;
            tens_q   <= tens_nxt;
            seg_q    <= seg_nxt;
            dig_en_q <= dig_en_nxt;
            err_q    <= err_nxt;
        end
    end

    assign seg    = seg_q;
    assign dig_en = dig_en_q;
    assign err    = err_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Bench for bcd_display_mux: directed scenarios then random traffic against a
// position-in-refresh-period reference model.
module tb_bcd_display_mux;

    localparam int R   = 4;
    localparam int B   = 2;
    localparam int PER = 2 * (R + B);

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] bcd_in;
    logic [6:0] seg;
    logic [1:0] dig_en;
    logic       err;

    int errors = 0;
    int checks = 0;

    // Reference model: t = cycles since display entry (-1 when idle).
    int         t;
    logic [3:0] cu, ct;
    logic       bad, err_m;

    logic [6:0] seg_tab [16];
    logic [1:0] exp_de_025 [12];

    bcd_display_mux #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .bcd_in (bcd_in),
        .seg    (seg),
        .dig_en (dig_en),
        .err    (err)
    );

    always #5 clk = ~clk;

    function automatic int pos_of(input int tt);
        return (tt < 0) ? -1 : (tt % PER);
    endfunction

    task automatic model_reset();
        t = -1; cu = 4'd0; ct = 4'd0; bad = 1'b0; err_m = 1'b0;
    endtask

    task automatic model_edge();
        int p;
        err_m = err_m | bad;
        if (!ena) t = -1;
        else begin
            t = t + 1;
            p = t % PER;
            if (p == 0) begin
                cu = bcd_in[3:0];
                bad = bad | (cu > 4'd9);
            end
            if (p == R + B) begin
                ct = bcd_in[7:4];
                bad = bad | (ct > 4'd9);
            end
        end
    endtask

    task automatic expect_out(output logic [1:0] de, output logic [6:0] sg);
        int p;
        p = pos_of(t);
        de = 2'b00; sg = 7'h00;
        if (p >= 0 && p < R) begin
            de = 2'b01; sg = seg_tab[cu];
        end else if (p >= R + B && p < 2 * R + B) begin
`ifdef LEADING_ZERO_BLANK_EN
            if (ct != 4'd0) begin de = 2'b10; sg = seg_tab[ct]; end
`else
            de = 2'b10; sg = seg_tab[ct];
`endif
        end
    endtask

    task automatic check_all(input string tag);
        logic [1:0] de;
        logic [6:0] sg;
        expect_out(de, sg);
        checks++;
        assert (dig_en === de) else begin
            errors++;
            $error("FAIL %s dig_en t=%0d got=%b exp=%b", tag, t, dig_en, de);
        end
        checks++;
        assert (seg === sg) else begin
            errors++;
            $error("FAIL %s seg t=%0d got=%h exp=%h", tag, t, seg, sg);
        end
        checks++;
        assert (err === err_m) else begin
            errors++;
            $error("FAIL %s err t=%0d got=%b exp=%b", tag, t, err, err_m);
        end
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Advance until the model sits at the given refresh position.
    task automatic run_to(input int target, input string tag);
        int n = 0;
        while (pos_of(t) != target && n < 4 * PER) begin
            tick(tag);
            n++;
        end
        checks++;
        assert (pos_of(t) == target) else begin
            errors++;
            $error("FAIL %s run_to got=%0d exp=%0d", tag, pos_of(t), target);
        end
    endtask

    // Assert reset between edges, check, and release before the next edge.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        exp_de_025 = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00,
                       2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
        model_reset();
        rst_n = 1'b0; ena = 1'b0; bcd_in = 8'h00;

        #12;
        check_all("reset");

        // Basic refresh, released from reset with ena already high.
        bcd_in = 8'h47; ena = 1'b1;
        #4 rst_n = 1'b1;
        for (int i = 0; i < 2 * PER; i++) begin
            tick("basic");
            checks++;
            assert (dig_en === exp_de_025[i % PER]) else begin
                errors++;
                $error("FAIL basic_seq cyc=%0d got=%b exp=%b", i, dig_en, exp_de_025[i % PER]);
            end
        end

        // Input change in the middle of SHOW0.
        run_to(PER - 1, "mid_align");
        bcd_in = 8'h12;
        tick("mid");
        bcd_in = 8'h35;
        for (int i = 0; i < PER; i++) tick("mid");
        run_to(R + B, "mid_tens");
        checks++;
        assert (seg === 7'h4F) else begin
            errors++;
            $error("FAIL mid_tens seg got=%h exp=%h", seg, 7'h4F);
        end

        // Leading zero tens.
        bcd_in = 8'h05;
        for (int i = 0; i < 2 * PER; i++) tick("lead0");

        // Invalid nibble, then valid data; err must stay set.
        run_to(PER - 1, "inv_align");
        bcd_in = 8'h0C;
        tick("inv_cap");
        tick("inv_err");
        checks++;
        assert (err === 1'b1) else begin
            errors++;
            $error("FAIL inv_err err got=%b exp=1", err);
        end
        bcd_in = 8'h00;
        for (int i = 0; i < 2 * PER; i++) tick("inv_hold");

        // Enable drop on the second SHOW1 cycle, then re-enable.
        bcd_in = 8'h68;
        run_to(R + B + 1, "ena_align");
        ena = 1'b0;
        tick("ena_drop");
        bcd_in = 8'h93;
        ena = 1'b1;
        tick("ena_back");
        checks++;
        assert (dig_en === 2'b01 && seg === 7'h4F) else begin
            errors++;
            $error("FAIL ena_back got=%b/%h exp=01/4f", dig_en, seg);
        end
        for (int i = 0; i < PER; i++) tick("ena_run");

        // Async reset mid SHOW0 with err set.
        run_to(1, "rst_align");
        async_reset("async_rst");
        for (int i = 0; i < PER; i++) tick("post_rst");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] hi, lo;
            hi = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            lo = ($urandom_range(0, 14) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) hi = 4'd0;
            bcd_in = {hi, lo};
            ena = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 149) == 0) async_reset("rand_rst");
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_display_mux.md
BCD_DISPLAY_MUX -- requirements
Module: bcd_display_mux

Interface
REQ-001 Parameter REFRESH_DIV, default 1000, clock cycles each digit is shown per refresh phase; legal range 1 to 65535.
REQ-002 Parameter BLANK_CYCLES, default 16, clock cycles of all-off gap between digit phases for anti-ghosting; legal range 1 to 255.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 ena  input  1  enable, high when the design is selected.
REQ-006 bcd_in  input  8  packed BCD from the counter: [7:4] tens digit, [3:0] units digit.
REQ-007 seg  output  7  active-high segments {g,f,e,d,c,b,a}, registered.
REQ-008 dig_en  output  2  active-high digit select, [0] units, [1] tens; registered and one-hot or zero.
REQ-009 err  output  1  sticky flag: an invalid BCD nibble (>9) was captured.

Function
REQ-010 The FSM SHALL have states IDLE, SHOW0, GAP0, SHOW1 and GAP1.
- IDLE to SHOW0 when ena=1.
- SHOW0 to GAP0 after REFRESH_DIV cycles.
- GAP0 to SHOW1 after BLANK_CYCLES cycles.
- SHOW1 to GAP1 after REFRESH_DIV cycles.
- GAP1 to SHOW0 after BLANK_CYCLES cycles.
REQ-011 A single phase counter SHALL count cycles within the current state and clear on every state transition.
REQ-012 Refresh period with ena held high SHALL be exactly 2*(REFRESH_DIV+BLANK_CYCLES) cycles.
REQ-013 The units nibble SHALL be captured only on entry to SHOW0, and the tens nibble only on entry to SHOW1; input changes mid-phase SHALL NOT alter the displayed pattern.
REQ-014 Output values per state:
- SHOW0: dig_en=01, seg=decode(units).
- SHOW1: dig_en=10, seg=decode(tens).
- IDLE, GAP0, GAP1: dig_en=00, seg=0000000.
REQ-015 Decode table, hex {g..a}: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
REQ-016 Any nibble 10-15 SHALL decode to 40 (dash).
REQ-017 err SHALL go high one cycle after an invalid nibble is captured, and SHALL stay high until reset, regardless of later valid data.
REQ-018 ena falling in any state SHALL, on the next edge: force IDLE, clear the phase counter, and drive dig_en=00 and seg=00; err is held.
REQ-019 ena re-asserted SHALL restart at SHOW0 with a fresh units capture; there is no resume from the interrupted phase.
REQ-020 Output registers SHALL change only on clock edges, so dig_en and seg switch in the same cycle with no glitch.

Reset
REQ-021 rst_n low SHALL immediately and asynchronously set state=IDLE, phase counter=0, captured nibbles=0, seg=00, dig_en=00 and err=0.
REQ-022 Reset release with ena=1 SHALL give dig_en=01 on the first rising edge after release.
REQ-023 Reset asserted mid-phase SHALL abort the phase with no further output activity.

Configuration
REQ-024 Macro LEADING_ZERO_BLANK_EN:
- Defined: a captured tens nibble of 0 SHALL give dig_en=00 and seg=00 for the whole SHOW1 phase; timing is unchanged.
- Undefined: a tens nibble of 0 displays 3F with dig_en=10.
- Units digit behaviour is the same in both builds.

Verification
Bench parameters: REFRESH_DIV=4, BLANK_CYCLES=2.
REQ-025 Basic refresh. Stimulus: bcd_in=8'h47, ena=1 after reset. Response: dig_en 01,01,01,01,00,00,10,10,10,10,00,00, repeating with period 12; seg=07 during units, 66 during tens.
REQ-026 Mid-phase change. Stimulus: bcd_in=8'h12 during SHOW0, changed to 8'h35 on the second SHOW0 cycle. Response: seg stays 5B for the rest of SHOW0; the next SHOW1 shows 4F (tens=3).
REQ-027 Invalid digit. Stimulus: bcd_in=8'h0C. Response: seg=40 in SHOW0, err=1 from the cycle after capture; err stays 1 after bcd_in=8'h00.
REQ-028 Leading zero. Stimulus: bcd_in=8'h05. Response with LEADING_ZERO_BLANK_EN: SHOW1 gives dig_en=00, seg=00. Response without: dig_en=10, seg=3F.
REQ-029 Enable drop. Stimulus: ena=0 on the second SHOW1 cycle. Response: next cycle dig_en=00, seg=00. Stimulus: ena=1. Response: next cycle dig_en=01 with a fresh units capture.
REQ-030 Async reset. Stimulus: rst_n low between clock edges during SHOW0 with err=1. Response: dig_en=00, seg=00, err=0 before the next edge.
